stopwatch_tick_ctrl: RTL

//  Run/pause/adjust sequencer for the stopwatch timebase. It owns the seconds divider count, and

---
 rtl/stopwatch_tick_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/stopwatch_tick_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_tick_ctrl
//   Run/pause/adjust sequencer for the stopwatch timebase. Owns the seconds
//   divider and emits one-cycle sec_tick pulses only while RUN, adj_tick pulses
//   and a blink phase while ADJUST, and a free-running refresh_tick for the
//   display multiplexer.
//
// Parameters
//   SEC_DIV      clk cycles per sec_tick            (>= 2)
//   FAST_DIV     clk cycles per adj_tick / blink    (>= 2)
//   REFRESH_DIV  clk cycles per refresh_tick        (>= 2)
//
// Ports
//   clk_i           in   1  system clock, rising edge
//   rst_i           in   1  asynchronous active-high reset
//   start_stop_i    in   1  single-cycle pulse, one event per high cycle
//   clear_i         in   1  single-cycle pulse, back to IDLE, divider zeroed
//   adjust_i        in   1  level, requests adjust mode
//   sec_tick_o      out  1  one pulse per SEC_DIV counting RUN cycles
//   adj_tick_o      out  1  one pulse per FAST_DIV counting ADJUST cycles
//   refresh_tick_o  out  1  one pulse per REFRESH_DIV cycles, always running
//   blink_o         out  1  adjust blink phase, 0 outside ADJUST
//   state_o         out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 ADJUST
// -----------------------------------------------------------------------------
module stopwatch_tick_ctrl #(
  parameter int unsigned SEC_DIV     = 100_000_000,
  parameter int unsigned FAST_DIV    = 50_000_000,
  parameter int unsigned REFRESH_DIV = 250_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_stop_i,
  input  logic       clear_i,
  input  logic       adjust_i,
  output logic       sec_tick_o,
  output logic       adj_tick_o,
  output logic       refresh_tick_o,
  output logic       blink_o,
  output logic [1:0] state_o
);

  localparam int unsigned SEC_W = $clog2(SEC_DIV);
  localparam int unsigned ADJ_W = $clog2(FAST_DIV);
  localparam int unsigned REF_W = $clog2(REFRESH_DIV);

  localparam logic [SEC_W-1:0] SEC_MAX  = SEC_W'(SEC_DIV - 1);
  localparam logic [ADJ_W-1:0] ADJ_MAX  = ADJ_W'(FAST_DIV - 1);
  localparam logic [REF_W-1:0] REF_MAX  = REF_W'(REFRESH_DIV - 1);
  localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);
  localparam logic [ADJ_W-1:0] ADJ_ONE  = ADJ_W'(1);
  localparam logic [REF_W-1:0] REF_ONE  = REF_W'(1);
  localparam logic [SEC_W-1:0] SEC_ZERO = {SEC_W{1'b0}};
  localparam logic [ADJ_W-1:0] ADJ_ZERO = {ADJ_W{1'b0}};
  localparam logic [REF_W-1:0] REF_ZERO = {REF_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSE  = 2'b10,
    ST_ADJUST = 2'b11
  } state_e;

  state_e           state_q,        state_d;
  logic [SEC_W-1:0] sec_cnt_q,      sec_cnt_d;
  logic [ADJ_W-1:0] adj_cnt_q,      adj_cnt_d;
  logic [REF_W-1:0] ref_cnt_q,      ref_cnt_d;
  logic             blink_q,        blink_d;
  logic             sec_tick_q,     sec_tick_d;
  logic             adj_tick_q,     adj_tick_d;
  logic             refresh_tick_q, refresh_tick_d;

  // Sequencer next state: commands, divider counting and tick generation.
  // Counting happens only on edges where the state does not change, so the
  // edge that enters or leaves a mode never advances a divider.
  always_comb begin
    state_d    = state_q;
    sec_cnt_d  = sec_cnt_q;
    adj_cnt_d  = adj_cnt_q;
    blink_d    = blink_q;
    sec_tick_d = 1'b0;
    adj_tick_d = 1'b0;

    if (clear_i) begin
      state_d   = ST_IDLE;
      sec_cnt_d = SEC_ZERO;
      adj_cnt_d = ADJ_ZERO;
      blink_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_PAUSE: begin
          if (adjust_i) begin
            state_d   = ST_ADJUST;
            adj_cnt_d = ADJ_ZERO;
            blink_d   = 1'b0;
          end else if (start_stop_i) begin
            state_d = ST_RUN;
          end else begin
            state_d = state_q;
          end
        end
        ST_RUN: begin
          // Pausing keeps sec_cnt so the partial second survives resume.
          if (start_stop_i) begin
            state_d = ST_PAUSE;
          end else if (sec_cnt_q == SEC_MAX) begin
            sec_cnt_d  = SEC_ZERO;
            sec_tick_d = 1'b1;
          end else begin
            sec_cnt_d = sec_cnt_q + SEC_ONE;
          end
        end
        ST_ADJUST: begin
          // Leaving adjust restarts the second from zero.
          if (!adjust_i) begin
            state_d   = ST_PAUSE;
            sec_cnt_d = SEC_ZERO;
            blink_d   = 1'b0;
          end else if (adj_cnt_q == ADJ_MAX) begin
            adj_cnt_d  = ADJ_ZERO;
            adj_tick_d = 1'b1;
            blink_d    = ~blink_q;
          end else begin
            adj_cnt_d = adj_cnt_q + ADJ_ONE;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          sec_cnt_d = SEC_ZERO;
          adj_cnt_d = ADJ_ZERO;
          blink_d   = 1'b0;
        end
      endcase
    end
  end

  // Display refresh divider: free-running in every state, ignores clear.
  always_comb begin
    if (ref_cnt_q == REF_MAX) begin
      ref_cnt_d      = REF_ZERO;
      refresh_tick_d = 1'b1;
    end else begin
      ref_cnt_d      = ref_cnt_q + REF_ONE;
      refresh_tick_d = 1'b0;
    end
  end

  // State, divider and output registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      sec_cnt_q      <= SEC_ZERO;
      adj_cnt_q      <= ADJ_ZERO;
      ref_cnt_q      <= REF_ZERO;
      blink_q        <= 1'b0;
      sec_tick_q     <= 1'b0;
      adj_tick_q     <= 1'b0;
      refresh_tick_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sec_cnt_q      <= sec_cnt_d;
      adj_cnt_q      <= adj_cnt_d;
      ref_cnt_q      <= ref_cnt_d;
      blink_q        <= blink_d;
      sec_tick_q     <= sec_tick_d;
      adj_tick_q     <= adj_tick_d;
      refresh_tick_q <= refresh_tick_d;
    end
  end

  assign sec_tick_o     = sec_tick_q;
  assign adj_tick_o     = adj_tick_q;
  assign refresh_tick_o = refresh_tick_q;
  assign blink_o        = blink_q;
  assign state_o        = state_q;

endmodule
